// File: rtl/bf_channel_sequencer_if.sv
// Sample-memory read port and beamformer output stream of bf_channel_sequencer.
// The sequencer drives the master side; memory and beamformer sit on the slave side.
interface bf_channel_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int PIX_W  = 1
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              out_last;
    logic [PIX_W-1:0]  out_pixel;
    logic              out_mode;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output out_data, out_valid, out_first, out_last, out_pixel, out_mode,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  out_data, out_valid, out_first, out_last, out_pixel, out_mode,
        output out_ready
    );
endinterface

// File: rtl/bf_channel_sequencer.sv
// Streams CHANNELS samples per pixel from sample memory to a beamformer, with a
// drain gap after each pixel; a 2-entry skid FIFO absorbs the 1-cycle read latency.
module bf_channel_sequencer #(
    parameter int CHANNELS   = 128,
    parameter int PIXELS     = 1,
    parameter int DATA_W     = 16,
    parameter int GAP_CYCLES = 5,
    parameter int ADDR_W     = 8,
    parameter int PIX_W      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic mode_in,
    output logic busy,
    output logic done,
    bf_channel_sequencer_if.master bus
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              first;
        logic              last;
        logic [PIX_W-1:0]  pixel;
    } entry_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              issued_all_q, issued_all_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic              inflight_q;
    logic              tag_first_q, tag_last_q;
    logic [PIX_W-1:0]  tag_pix_q;

    entry_t            fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;

    entry_t            head;
    logic              rd_en, push, pop, flush, advance;
    logic [2:0]        occupancy;

    assign head          = fifo_q[rd_ptr_q];
    assign bus.out_valid = (count_q != 2'd0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign push          = inflight_q && !flush;

    // Reads are only issued when the returning sample is guaranteed a FIFO slot.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en     = (state_q == STREAM) && !issued_all_q && !abort && (occupancy < 3'd2);

    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = ADDR_W'(pix_q) * ADDR_W'(CHANNELS) + ADDR_W'(ch_q);
    assign bus.out_data  = bus.out_valid ? head.data  : '0;
    assign bus.out_first = bus.out_valid && head.first;
    assign bus.out_last  = bus.out_valid && head.last;
    assign bus.out_pixel = bus.out_valid ? head.pixel : '0;
    assign bus.out_mode  = mode_q;

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE) && !abort;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        pix_d        = pix_q;
        ch_d         = ch_q;
        issued_all_d = issued_all_q;
        gap_d        = gap_q;
        flush        = 1'b0;
        advance      = 1'b0;

        if (rd_en) begin
            if (ch_q == CH_LAST) issued_all_d = 1'b1;
            else                 ch_d         = ch_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = STREAM;
                    mode_d       = mode_in;
                    pix_d        = '0;
                    ch_d         = '0;
                    issued_all_d = 1'b0;
                    flush        = 1'b1;
                end
            end
            STREAM: begin
                if (pop && head.last) begin
                    if (GAP_CYCLES == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) advance = 1'b1;
                else                   gap_d   = gap_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                pix_d   = '0;
                ch_d    = '0;
            end
        endcase

        if (advance) begin
            if (pix_q == PIX_LAST) begin
                state_d = DONE;
            end else begin
                state_d      = STREAM;
                pix_d        = pix_q + 1'b1;
                ch_d         = '0;
                issued_all_d = 1'b0;
            end
        end

        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            pix_d        = '0;
            ch_d         = '0;
            issued_all_d = 1'b0;
            flush        = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            pix_q        <= '0;
            ch_q         <= '0;
            issued_all_q <= 1'b0;
            gap_q        <= '0;
            inflight_q   <= 1'b0;
            tag_first_q  <= 1'b0;
            tag_last_q   <= 1'b0;
            tag_pix_q    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            pix_q        <= pix_d;
            ch_q         <= ch_d;
            issued_all_q <= issued_all_d;
            gap_q        <= gap_d;
            inflight_q   <= rd_en;
            if (rd_en) begin
                tag_first_q <= (ch_q == '0);
                tag_last_q  <= (ch_q == CH_LAST);
                tag_pix_q   <= pix_q;
            end
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                count_q  <= 2'd0;
            end else begin
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop)  rd_ptr_q <= ~rd_ptr_q;
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // NOTE: FIFO storage is not reset; the head is masked by out_valid, so stale entries never reach the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{data: bus.rd_data, first: tag_first_q,
                                  last: tag_last_q, pixel: tag_pix_q};
        end
    end
endmodule

// File: tb/tb_bf_channel_sequencer.sv
// Directed bench for bf_channel_sequencer: three configurations (128x1 gap 5,
// 4x3 gap 2, 1x2 gap 0), each fed by a ramp memory where address N holds N.
module tb_bf_channel_sequencer;
    logic clk;
    logic rst;
    logic start_a, abort_a, mode_a, busy_a, done_a;
    logic start_b, abort_b, mode_b, busy_b, done_b;
    logic start_c, abort_c, mode_c, busy_c, done_c;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bf_channel_sequencer_if #(.DATA_W(16), .ADDR_W(8), .PIX_W(1)) bus_a ();
    bf_channel_sequencer_if #(.DATA_W(16), .ADDR_W(4), .PIX_W(2)) bus_b ();
    bf_channel_sequencer_if #(.DATA_W(16), .ADDR_W(1), .PIX_W(1)) bus_c ();

    bf_channel_sequencer #(.CHANNELS(128), .PIXELS(1), .DATA_W(16), .GAP_CYCLES(5),
                           .ADDR_W(8), .PIX_W(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .mode_in(mode_a),
        .busy(busy_a), .done(done_a), .bus(bus_a));

    bf_channel_sequencer #(.CHANNELS(4), .PIXELS(3), .DATA_W(16), .GAP_CYCLES(2),
                           .ADDR_W(4), .PIX_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .mode_in(mode_b),
        .busy(busy_b), .done(done_b), .bus(bus_b));

    bf_channel_sequencer #(.CHANNELS(1), .PIXELS(2), .DATA_W(16), .GAP_CYCLES(0),
                           .ADDR_W(1), .PIX_W(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .mode_in(mode_c),
        .busy(busy_c), .done(done_c), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ramp memories with one-cycle read latency.
    always @(posedge clk) if (bus_a.rd_en) bus_a.rd_data <= 16'(bus_a.rd_addr);
    always @(posedge clk) if (bus_b.rd_en) bus_b.rd_data <= 16'(bus_b.rd_addr);
    always @(posedge clk) if (bus_c.rd_en) bus_c.rd_data <= 16'(bus_c.rd_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_ramp_a(input string tag);
        int  k;
        bit  seen;
        k    = 0;
        seen = 1'b0;
        bus_a.out_ready = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            if (bus_a.out_valid) begin
                check({tag, "_data"}, 32'(bus_a.out_data), k);
                k++;
            end
            if (done_a) seen = 1'b1;
            step();
        end
        check({tag, "_count"}, k, 128);
        check({tag, "_done"}, 32'(seen), 1);
    endtask

    initial begin
        int          k, dones, done_cyc, p1_cyc;
        bit          seen, stalled;
        logic [15:0] held;
        int          vc [2];

        rst = 1'b0;
        {start_a, abort_a, mode_a} = 3'b000;
        {start_b, abort_b, mode_b} = 3'b000;
        {start_c, abort_c, mode_c} = 3'b000;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        bus_c.out_ready = 1'b1;
        #1;

        check("rst_busy",   32'(busy_a), 0);
        check("rst_done",   32'(done_a), 0);
        check("rst_rd_en",  32'(bus_a.rd_en), 0);
        check("rst_addr",   32'(bus_a.rd_addr), 0);
        check("rst_valid",  32'(bus_a.out_valid), 0);
        check("rst_data",   32'(bus_a.out_data), 0);
        check("rst_first",  32'(bus_a.out_first), 0);
        check("rst_last",   32'(bus_a.out_last), 0);
        check("rst_pixel",  32'(bus_a.out_pixel), 0);
        check("rst_mode",   32'(bus_a.out_mode), 0);
        check("rst_b_busy", 32'(busy_b), 0);
        check("rst_c_busy", 32'(busy_c), 0);

        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        step();

        // Full 128-channel frame with exact latency, gap and done timing.
        check("a_idle_busy", 32'(busy_a), 0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("a_c0_busy",  32'(busy_a), 1);
        check("a_c0_rd_en", 32'(bus_a.rd_en), 1);
        check("a_c0_addr",  32'(bus_a.rd_addr), 0);
        check("a_c0_valid", 32'(bus_a.out_valid), 0);
        step();
        check("a_c1_rd_en", 32'(bus_a.rd_en), 1);
        check("a_c1_addr",  32'(bus_a.rd_addr), 1);
        check("a_c1_valid", 32'(bus_a.out_valid), 0);
        for (int i = 0; i < 128; i++) begin
            step();
            check("a_valid", 32'(bus_a.out_valid), 1);
            check("a_data",  32'(bus_a.out_data), i);
            check("a_first", 32'(bus_a.out_first), 32'(i == 0));
            check("a_last",  32'(bus_a.out_last), 32'(i == 127));
        end
        for (int i = 0; i < 5; i++) begin
            step();
            check("a_gap_valid", 32'(bus_a.out_valid), 0);
            check("a_gap_rd_en", 32'(bus_a.rd_en), 0);
            check("a_gap_busy",  32'(busy_a), 1);
            check("a_gap_done",  32'(done_a), 0);
        end
        step();
        check("a_done", 32'(done_a), 1);
        step();
        check("a_done_clr", 32'(done_a), 0);
        check("a_idle",     32'(busy_a), 0);

        // Random back-pressure: order preserved, head held stable while stalled.
        k = 0; seen = 1'b0; stalled = 1'b0; held = '0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 0; c < 1500 && !seen; c++) begin
            if (stalled) begin
                check("r_stall_valid", 32'(bus_a.out_valid), 1);
                check("r_stall_data",  32'(bus_a.out_data), 32'(held));
            end
            if (done_a) seen = 1'b1;
            bus_a.out_ready = 1'($urandom_range(0, 1));
            stalled = 1'b0;
            if (bus_a.out_valid) begin
                if (bus_a.out_ready) begin
                    check("r_data", 32'(bus_a.out_data), k);
                    k++;
                end else begin
                    stalled = 1'b1;
                    held    = bus_a.out_data;
                end
            end
            step();
        end
        check("r_count", k, 128);
        check("r_done",  32'(seen), 1);
        bus_a.out_ready = 1'b1;

        // 4x3 frame with gap 2: mode toggling, ignored starts mid-frame and in DONE.
        k = 0; dones = 0; done_cyc = -1; p1_cyc = -1;
        mode_b  = 1'b1;
        start_b = 1'b1;
        step();
        for (int c = 0; c < 40; c++) begin
            if (bus_b.out_valid) begin
                check("b_data",  32'(bus_b.out_data), k);
                check("b_pixel", 32'(bus_b.out_pixel), k / 4);
                check("b_first", 32'(bus_b.out_first), 32'((k % 4) == 0));
                check("b_last",  32'(bus_b.out_last), 32'((k % 4) == 3));
                check("b_mode",  32'(bus_b.out_mode), 1);
                if (k == 4) p1_cyc = c;
                k++;
            end
            if (c == 6 || c == 7 || c == 14 || c == 15) check("b_gap_rd_en", 32'(bus_b.rd_en), 0);
            if (c < 24)  check("b_busy", 32'(busy_b), 1);
            if (c >= 25) check("b_idle", 32'(busy_b), 0);
            if (done_b) begin
                dones++;
                done_cyc = c;
            end
            start_b = (c == 4 || c == 24);
            mode_b  = ~mode_b;
            step();
        end
        start_b = 1'b0;
        check("b_count",    k, 12);
        check("b_dones",    dones, 1);
        check("b_p1_cyc",   p1_cyc, 10);
        check("b_done_cyc", done_cyc, 24);

        // Single channel, zero gap: first and last on the same sample.
        k = 0; done_cyc = -1; vc[0] = -1; vc[1] = -1;
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bus_c.out_valid) begin
                check("c_data",  32'(bus_c.out_data), k);
                check("c_pixel", 32'(bus_c.out_pixel), k);
                check("c_first", 32'(bus_c.out_first), 1);
                check("c_last",  32'(bus_c.out_last), 1);
                if (k < 2) vc[k] = c;
                k++;
            end
            if (done_c) done_cyc = c;
            step();
        end
        check("c_count",    k, 2);
        check("c_cyc0",     vc[0], 2);
        check("c_cyc1",     vc[1], 5);
        check("c_done_cyc", done_cyc, 6);

        // Start and abort together in IDLE: start wins; abort then cancels.
        start_a = 1'b1;
        abort_a = 1'b1;
        step();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("sa_busy", 32'(busy_a), 1);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("sa_abort_busy", 32'(busy_a), 0);
        check("sa_abort_done", 32'(done_a), 0);

        // Abort at channel 60.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 0; c < 300 && !(bus_a.out_valid && bus_a.out_data == 16'd60); c++) step();
        check("ab_reach", 32'(bus_a.out_data), 60);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("ab_busy",  32'(busy_a), 0);
        check("ab_valid", 32'(bus_a.out_valid), 0);
        check("ab_rd_en", 32'(bus_a.rd_en), 0);
        check("ab_done",  32'(done_a), 0);
        dones = 0;
        repeat (10) begin
            step();
            if (done_a) dones++;
        end
        check("ab_nodone", dones, 0);
        run_ramp_a("ab_restart");

        // Asynchronous reset at channel 30.
        mode_a  = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        mode_a  = 1'b0;
        for (int c = 0; c < 300 && !(bus_a.out_valid && bus_a.out_data == 16'd30); c++) step();
        check("ar_reach", 32'(bus_a.out_data), 30);
        check("ar_mode",  32'(bus_a.out_mode), 1);
        #1 rst = 1'b0;
        #1;
        check("ar_busy",  32'(busy_a), 0);
        check("ar_rd_en", 32'(bus_a.rd_en), 0);
        check("ar_addr",  32'(bus_a.rd_addr), 0);
        check("ar_valid", 32'(bus_a.out_valid), 0);
        check("ar_data",  32'(bus_a.out_data), 0);
        check("ar_first", 32'(bus_a.out_first), 0);
        check("ar_mode0", 32'(bus_a.out_mode), 0);
        check("ar_done",  32'(done_a), 0);
        step();
        rst = 1'b1;
        dones = 0;
        repeat (3) begin
            step();
            if (done_a || busy_a) dones++;
        end
        check("ar_quiet", dones, 0);
        run_ramp_a("ar_restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bf_channel_sequencer.md
BF_CHANNEL_SEQUENCER -- requirements
Module: bf_channel_sequencer

Interface
REQ-001 Parameters SHALL be: CHANNELS, default 128, channels per pixel; PIXELS, default 1, pixels per frame; DATA_W, default 16, signed sample width; GAP_CYCLES, default 5, idle cycles after each pixel for beamformer drain; ADDR_W, default 8, memory address width (>= clog2(CHANNELS*PIXELS)); PIX_W, default 1, pixel index width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 start  input  1  one-cycle frame start request.
REQ-005 abort  input  1  synchronous frame cancel.
REQ-006 mode_in  input  1  beamforming mode request (0 = DAS, 1 = DMAS).
REQ-007 rd_en  output  1  sample memory read strobe.
REQ-008 rd_addr  output  ADDR_W  sample memory address.
REQ-009 rd_data  input  DATA_W  memory read data, valid exactly one cycle after rd_en.
REQ-010 out_data  output  DATA_W  signed channel sample to beamformer.
REQ-011 out_valid / out_ready  output / input  1 each  stream handshake; transfer when both are high on a rising edge.
REQ-012 out_first / out_last  output  1 each  marks channel 0 / channel CHANNELS-1 of a pixel; qualified by out_valid.
REQ-013 out_pixel  output  PIX_W  pixel index of out_data.
REQ-014 out_mode  output  1  mode latched for the current frame.
REQ-015 busy  output  1  high from the cycle after start acceptance until done.
REQ-016 done  output  1  one-cycle pulse at frame completion.

Function
REQ-017 FSM states SHALL be IDLE, STREAM, GAP, DONE.
REQ-018 IDLE: start=1 SHALL latch mode_in into out_mode, clear pixel and channel counters, and go to STREAM; start outside IDLE SHALL be ignored.
REQ-019 rd_addr SHALL equal pixel*CHANNELS + ch_issue; ch_issue increments per rd_en and stops at CHANNELS-1 for the pixel.
REQ-020 Samples SHALL be buffered in a 2-entry FIFO; rd_en SHALL assert only when fifo_count + in_flight - pop < 2, so no returned sample is ever dropped.
REQ-021 out_valid SHALL equal FIFO non-empty; out_data/first/last/pixel SHALL come from the FIFO head and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 With out_ready held high, rd_en SHALL assert the cycle after start is sampled, first out_valid SHALL follow two cycles after start, and one sample per cycle SHALL be delivered thereafter (CHANNELS consecutive transfers).
REQ-023 Transfer of the out_last sample SHALL move STREAM -> GAP; GAP SHALL last exactly GAP_CYCLES cycles with out_valid=0 and rd_en=0.
REQ-024 GAP end: if pixel < PIXELS-1, pixel increments and state returns to STREAM; else state goes to DONE.
REQ-025 DONE SHALL last one cycle with done=1, busy=0 in the next cycle, then IDLE; a start in DONE SHALL be ignored.
REQ-026 mode_in changes while busy SHALL not affect out_mode.
REQ-027 abort=1 in any non-IDLE state SHALL flush the FIFO, discard in-flight reads, return to IDLE next cycle, and SHALL NOT pulse done; abort in IDLE SHALL have no effect; abort and start together in IDLE SHALL accept start.
REQ-028 CHANNELS=1 SHALL assert out_first and out_last on the same sample; GAP_CYCLES=0 SHALL go directly from the last transfer to the next pixel or DONE.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, empty FIFO, counters 0, and rd_en, rd_addr, out_valid, out_data, out_first, out_last, out_pixel, out_mode, busy, done all 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no done pulse; the first start after release SHALL begin at pixel 0, channel 0.

Verification
REQ-031 CHANNELS=128, PIXELS=1, ramp memory (addr N holds N), ready=1, start -> 128 transfers values 0..127, first on 0, last on 127, 5 idle cycles, done pulse.
REQ-032 PIXELS=3, CHANNELS=4, GAP_CYCLES=2 -> 12 transfers addr 0..11, out_pixel 0,0,0,0,1,...,2, 2-cycle gaps between pixels, single done.
REQ-033 Random out_ready (50%) over a full frame -> no lost, duplicated or reordered sample; outputs stable during stall.
REQ-034 mode_in=1 at start then toggled every cycle -> out_mode=1 for the whole frame; second start mid-frame ignored.
REQ-035 abort at channel 60 of 128 -> IDLE next cycle, no done; restart produces a complete frame from address 0.
REQ-036 rst=0 asynchronously at channel 30 -> all outputs 0 immediately; after release, start yields a clean frame.
